matinv_sched: RTL and testbench

Round-robin scheduler that shares one pipelined 2x2 matrix inverter datapath among N requesters. It accepts matrices over per-port valid/ready handshakes and issues at most one matrix per cycle to the inverter. A tag pipeline tracks each issued matrix, so every inverse and singular-matrix error returns to the requester that issued it. It sits between client blocks and the inverter instance at the top level.

---
 rtl/matinv_pkg.sv | 31 +++
 rtl/matinv_rr_arb.sv | 33 +++
 rtl/matinv_sched.sv | 170 +++++++++++++++++
 tb/tb_matinv_sched.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/matinv_pkg.sv
// Shared types and constants for the 2x2 matrix inverter scheduler:
// Q2.14 element format, matrix word field offsets and the tag record.
package matinv_pkg;

  localparam int IN_I   = 2;
  localparam int IN_F   = 14;
  localparam int ELEM_W = IN_I + IN_F;
  localparam int MAT_W  = 4 * ELEM_W;

  // Matrix word is {a, b, c, d} with a in the most significant bits.
  localparam int A_LSB = 3 * ELEM_W;
  localparam int B_LSB = 2 * ELEM_W;
  localparam int C_LSB = 1 * ELEM_W;
  localparam int D_LSB = 0;

  // Port index width covers the largest supported port count (8).
  localparam int IDX_W = 3;
  localparam int CNT_W = 4;

  typedef logic [ELEM_W-1:0] elem_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  function automatic elem_t mat_field(input logic [MAT_W-1:0] mat, input int lsb);
    return mat[lsb +: ELEM_W];
  endfunction

endpackage

// File: rtl/matinv_rr_arb.sv
// Combinational round-robin pick: first eligible port at or after rr_ptr,
// wrapping modulo N. Produces a one-hot grant and its index.
module matinv_rr_arb
  import matinv_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  // NOTE: every output of a combinational block is given a default before
  // any conditional assignment, so no path leaves a value held (no latch).
  always_comb begin
    int k;
    k         = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = (int'(rr_ptr) + i) % N;
      if (!grant_any && eligible[k]) begin
        grant[k]  = 1'b1;
        grant_idx = IDX_W'(k);
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/matinv_sched.sv
// Round-robin scheduler sharing one pipelined 2x2 matrix inverter among N ports.
// Optional build macro MATINV_SCHED_ERRCNT_EN adds a saturating singular-matrix counter.
module matinv_sched
  import matinv_pkg::*;
#(
  parameter int N       = 4,
  parameter int INV_LAT = 4,
  parameter int MAX_OUT = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sched_en,
  input  logic [N-1:0]       req_valid,
  output logic [N-1:0]       req_ready,
  input  logic [N*MAT_W-1:0] req_mat,
  output logic               inv_valid,
  output logic [ELEM_W-1:0]  inv_a,
  output logic [ELEM_W-1:0]  inv_b,
  output logic [ELEM_W-1:0]  inv_c,
  output logic [ELEM_W-1:0]  inv_d,
  input  logic [ELEM_W-1:0]  inv_a_inv,
  input  logic [ELEM_W-1:0]  inv_b_inv,
  input  logic [ELEM_W-1:0]  inv_c_inv,
  input  logic [ELEM_W-1:0]  inv_d_inv,
  input  logic               inv_error,
  output logic [N-1:0]       rsp_valid,
  output logic [MAT_W-1:0]   rsp_mat,
  output logic               rsp_error,
`ifdef MATINV_SCHED_ERRCNT_EN
  output logic [15:0]        err_count,
`endif
  output logic               busy
);

  logic [IDX_W-1:0] rr_ptr;
  logic [CNT_W-1:0] out_cnt [N];
  tag_t             tag_pipe [INV_LAT+1];
  tag_t             tag_in;
  tag_t             tag_out;

  logic [N-1:0]     eligible;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             xfer;
  logic [IDX_W-1:0] next_ptr;
  logic [MAT_W-1:0] granted_mat;
  logic [N-1:0]     rsp_onehot;

  // A response leaving this cycle frees its slot, so a full port may be
  // granted in the same cycle its oldest matrix returns.
  always_comb begin
    eligible = '0;
    for (int k = 0; k < N; k++) begin
      eligible[k] = sched_en && req_valid[k] &&
                    ((out_cnt[k] < CNT_W'(MAX_OUT)) || rsp_valid[k]);
    end
  end

  matinv_rr_arb #(.N(N)) u_arb (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (xfer)
  );

  assign req_ready = grant;
  assign next_ptr  = (grant_idx == IDX_W'(N-1)) ? '0 : grant_idx + IDX_W'(1);

  always_comb begin
    granted_mat = '0;
    for (int k = 0; k < N; k++) begin
      if (grant[k]) granted_mat = req_mat[k*MAT_W +: MAT_W];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr    <= '0;
      inv_valid <= 1'b0;
      inv_a     <= '0;
      inv_b     <= '0;
      inv_c     <= '0;
      inv_d     <= '0;
    end else begin
      inv_valid <= xfer;
      if (xfer) begin
        rr_ptr <= next_ptr;
        inv_a  <= mat_field(granted_mat, A_LSB);
        inv_b  <= mat_field(granted_mat, B_LSB);
        inv_c  <= mat_field(granted_mat, C_LSB);
        inv_d  <= mat_field(granted_mat, D_LSB);
      end
    end
  end

  // Stage 0 lines up with inv_valid; stage INV_LAT lines up with the
  // inverter result for that issue.
  always_comb begin
    tag_in.valid = xfer;
    tag_in.idx   = grant_idx;
  end

  assign tag_out = tag_pipe[INV_LAT];

  // NOTE: the tag array is reset entry by entry; its valid bits are what make
  // stale inverter results after reset harmless.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s <= INV_LAT; s++) tag_pipe[s] <= '0;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int s = 1; s <= INV_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  always_comb begin
    rsp_onehot = '0;
    for (int k = 0; k < N; k++) begin
      rsp_onehot[k] = tag_out.valid && (tag_out.idx == IDX_W'(k));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= '0;
      rsp_mat   <= '0;
      rsp_error <= 1'b0;
    end else if (tag_out.valid) begin
      rsp_valid <= rsp_onehot;
      rsp_error <= inv_error;
      rsp_mat   <= inv_error ? '0 : {inv_a_inv, inv_b_inv, inv_c_inv, inv_d_inv};
    end else begin
      rsp_valid <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) out_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        case ({grant[k], rsp_valid[k]})
          2'b10:   out_cnt[k] <= out_cnt[k] + CNT_W'(1);
          2'b01:   out_cnt[k] <= out_cnt[k] - CNT_W'(1);
          default: out_cnt[k] <= out_cnt[k];
        endcase
      end
    end
  end

  always_comb begin
    busy = |rsp_valid;
    for (int s = 0; s <= INV_LAT; s++) busy = busy | tag_pipe[s].valid;
    for (int k = 0; k < N; k++) busy = busy | (out_cnt[k] != '0);
  end

`ifdef MATINV_SCHED_ERRCNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if ((|rsp_valid) && rsp_error && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_matinv_sched.sv
// Directed bench for matinv_sched with a behavioural fixed-latency 2x2 inverter.
// Covers reset, identity, singular, fairness, outstanding limit, sched_en and mid-run reset.
module tb_matinv_sched;

  localparam int N       = 4;
  localparam int INV_LAT = 4;
  localparam int MAX_OUT = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            sched_en;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*64-1:0] req_mat;
  logic            inv_valid;
  logic [15:0]     inv_a, inv_b, inv_c, inv_d;
  logic [15:0]     inv_a_inv, inv_b_inv, inv_c_inv, inv_d_inv;
  logic            inv_error;
  logic [N-1:0]    rsp_valid;
  logic [63:0]     rsp_mat;
  logic            rsp_error;
  logic            busy;
`ifdef MATINV_SCHED_ERRCNT_EN
  logic [15:0]     err_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matinv_sched #(.N(N), .INV_LAT(INV_LAT), .MAX_OUT(MAX_OUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .sched_en  (sched_en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mat   (req_mat),
    .inv_valid (inv_valid),
    .inv_a     (inv_a),
    .inv_b     (inv_b),
    .inv_c     (inv_c),
    .inv_d     (inv_d),
    .inv_a_inv (inv_a_inv),
    .inv_b_inv (inv_b_inv),
    .inv_c_inv (inv_c_inv),
    .inv_d_inv (inv_d_inv),
    .inv_error (inv_error),
    .rsp_valid (rsp_valid),
    .rsp_mat   (rsp_mat),
    .rsp_error (rsp_error),
`ifdef MATINV_SCHED_ERRCNT_EN
    .err_count (err_count),
`endif
    .busy      (busy)
  );

  // Behavioural inverter: result INV_LAT cycles after the operands are presented.
  // Singular matrices return a flag plus deliberately non-zero junk data.
  function automatic logic [64:0] inv_fn(input logic [15:0] a, b, c, d);
    longint sa, sb, sc, sd, det;
    logic [15:0] ai, bi, ci, di;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sc  = longint'($signed(c));
    sd  = longint'($signed(d));
    det = sa * sd - sb * sc;
    if (det == 0) return {1'b1, 64'hDEAD_BEEF_1234_5678};
    ai = 16'((sd <<< 28) / det);
    bi = 16'((-sb <<< 28) / det);
    ci = 16'((-sc <<< 28) / det);
    di = 16'((sa <<< 28) / det);
    return {1'b0, ai, bi, ci, di};
  endfunction

  logic [64:0] model_pipe [INV_LAT];

  always @(posedge clk) begin
    model_pipe[0] <= inv_fn(inv_a, inv_b, inv_c, inv_d);
    for (int s = 1; s < INV_LAT; s++) model_pipe[s] <= model_pipe[s-1];
  end

  assign {inv_error, inv_a_inv, inv_b_inv, inv_c_inv, inv_d_inv} = model_pipe[INV_LAT-1];

  // Port k test matrix {1.0, k/64, 0, 1.0}; its inverse negates b.
  function automatic logic [63:0] port_mat(input int k);
    return {16'h4000, 16'(k * 256), 16'h0000, 16'h4000};
  endfunction

  function automatic logic [63:0] port_inv(input int k);
    return {16'h4000, 16'(-(k * 256)), 16'h0000, 16'h4000};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_mat(input int k, input logic [63:0] m);
    req_mat[k*64 +: 64] = m;
  endtask

  // One matrix from port p: grant at T, issue at T+1, response at T+6.
  task automatic single(input int p, input logic [63:0] m,
                        input logic [63:0] exp_mat, input logic exp_err);
    set_mat(p, m);
    req_valid[p] = 1'b1;
    #1;
    check("single_grant", 64'(req_ready), 64'(1) << p);
    @(negedge clk);
    req_valid = '0;
    check("single_inv_valid", 64'(inv_valid), 64'd1);
    check("single_inv_ops", {inv_a, inv_b, inv_c, inv_d}, m);
    check("single_busy", 64'(busy), 64'd1);
    repeat (4) @(negedge clk);
    check("single_rsp_early", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check("single_rsp_valid", 64'(rsp_valid), 64'(1) << p);
    check("single_rsp_mat", rsp_mat, exp_mat);
    check("single_rsp_error", 64'(rsp_error), 64'(exp_err));
    @(negedge clk);
    check("single_rsp_clear", 64'(rsp_valid), 64'd0);
    check("single_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    reset     = 1'b0;
    sched_en  = 1'b0;
    req_valid = '0;
    req_mat   = '0;
    repeat (3) @(negedge clk);

    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_inv_valid", 64'(inv_valid), 64'd0);
    check("rst_inv_ops", {inv_a, inv_b, inv_c, inv_d}, 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_mat", rsp_mat, 64'd0);
    check("rst_rsp_error", 64'(rsp_error), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
`ifdef MATINV_SCHED_ERRCNT_EN
    check("rst_err_count", 64'(err_count), 64'd0);
`endif

    reset    = 1'b1;
    sched_en = 1'b1;
    @(negedge clk);

    // Identity from port 0, then singular from port 2 (rr_ptr is 1 then).
    single(0, 64'h4000_0000_0000_4000, 64'h4000_0000_0000_4000, 1'b0);
    single(2, 64'h4000_4000_4000_4000, 64'd0, 1'b1);
`ifdef MATINV_SCHED_ERRCNT_EN
    check("err_count_one", 64'(err_count), 64'd1);
`endif

    // sched_en low blocks port 3; the grant appears as soon as it rises.
    sched_en = 1'b0;
    set_mat(3, port_mat(3));
    req_valid[3] = 1'b1;
    #1;
    check("en_off_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("en_off_ready2", 64'(req_ready), 64'd0);
    check("en_off_inv_valid", 64'(inv_valid), 64'd0);
    sched_en = 1'b1;
    single(3, port_mat(3), port_inv(3), 1'b0);

    // Fairness: rr_ptr is back at 0, all ports valid for 12 cycles.
    for (int k = 0; k < N; k++) set_mat(k, port_mat(k));
    req_valid = '1;
    for (int c = 0; c < 18; c++) begin
      if (c == 12) req_valid = '0;
      #1;
      if (c < 12) check("fair_grant", 64'(req_ready), 64'(1) << (c % 4));
      if (c >= 6) begin
        check("fair_rsp_valid", 64'(rsp_valid), 64'(1) << ((c - 6) % 4));
        check("fair_rsp_mat", rsp_mat, port_inv((c - 6) % 4));
      end
      @(negedge clk);
    end
    check("fair_idle", 64'(busy), 64'd0);

    // Outstanding limit on port 1: three grants, stall, resume with first response.
    set_mat(1, port_mat(1));
    req_valid = 4'b0010;
    for (int c = 0; c < 7; c++) begin
      #1;
      check("limit_ready", 64'(req_ready), (c < 3 || c == 6) ? 64'h2 : 64'h0);
      if (c == 6) check("limit_rsp_valid", 64'(rsp_valid), 64'h2);
      @(negedge clk);
    end

    // Reset with three matrices in flight; a response was due this cycle.
    req_valid = '0;
    reset     = 1'b0;
    #1;
    check("mid_rst_inv_valid", 64'(inv_valid), 64'd0);
    check("mid_rst_inv_ops", {inv_a, inv_b, inv_c, inv_d}, 64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_rsp_mat", rsp_mat, 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
`ifdef MATINV_SCHED_ERRCNT_EN
    check("mid_rst_err_count", 64'(err_count), 64'd0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      check("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
      @(negedge clk);
    end
    check("post_rst_idle", 64'(busy), 64'd0);

    // Ports 0 and 2 both request; port 0 wins because rr_ptr was reset.
    set_mat(2, port_mat(2));
    req_valid[2] = 1'b1;
    single(0, port_mat(0), port_inv(0), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
